systolic_feeder: RTL and testbench

SYSTOLIC_FEEDER -- requirements
Module: systolic_feeder

---
 rtl/systolic_feeder.sv | 150 +++++++++++++++
 tb/tb_systolic_feeder.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/systolic_feeder.sv
// Operand feeder for an N x N systolic array: collects N column/row beats of A and B,
// then replays them as a diagonally skewed stream followed by an all-zero drain.
module systolic_feeder #(
  parameter int data_width = 8,
  parameter int num_of_PE  = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [data_width*num_of_PE-1:0] in_a_col,
  input  logic [data_width*num_of_PE-1:0] in_b_row,
  output logic [data_width*num_of_PE-1:0] out_left,
  output logic [data_width*num_of_PE-1:0] out_up,
  output logic                           out_valid,
  output logic                           busy,
  output logic                           done
);

  localparam int N  = num_of_PE;
  localparam int DW = data_width;
  localparam int LW = DW * N;
  localparam int TW = ((3 * N - 2) > 1) ? $clog2(3 * N - 2) : 1;
  localparam int BW = (N > 1) ? $clog2(N) : 1;

  localparam logic [TW-1:0] T_LAST    = TW'(3 * N - 3);
  localparam logic [BW-1:0] BEAT_LAST = BW'(N - 1);

  typedef enum logic [1:0] {
    LOAD   = 2'd0,
    STREAM = 2'd1,
    DONE   = 2'd2
  } state_t;

  state_t          state;
  state_t          state_nxt;
  logic [BW-1:0]   beat;
  logic [BW-1:0]   beat_nxt;
  logic [TW-1:0]   t;
  logic [TW-1:0]   t_nxt;
  logic            accept;

  logic [DW-1:0]   a_buf [N][N];
  logic [DW-1:0]   a_nxt [N][N];
  logic [DW-1:0]   b_buf [N][N];
  logic [DW-1:0]   b_nxt [N][N];

  logic [LW-1:0]   left_nxt;
  logic [LW-1:0]   up_nxt;
  logic            valid_nxt;
  logic            done_nxt;

  assign in_ready = (state == LOAD);
  assign busy     = (state == STREAM) || (state == DONE);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= LOAD;
      beat      <= '0;
      t         <= '0;
      out_left  <= '0;
      out_up    <= '0;
      out_valid <= 1'b0;
      done      <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat      <= beat_nxt;
      t         <= t_nxt;
      out_left  <= left_nxt;
      out_up    <= up_nxt;
      out_valid <= valid_nxt;
      done      <= done_nxt;
    end
  end

  // Operand storage is deliberately not reset; a new job always rewrites every entry.
  always_ff @(posedge clk) begin
    a_buf <= a_nxt;
    b_buf <= b_nxt;
  end

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    t_nxt     = t;
    case (state)
      LOAD: begin
        if (accept) begin
          if (beat == BEAT_LAST) begin
            state_nxt = STREAM;
            beat_nxt  = '0;
            t_nxt     = '0;
          end else begin
            beat_nxt = beat + 1'b1;
          end
        end
      end
      STREAM: begin
        if (t == T_LAST) begin
          state_nxt = DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t + 1'b1;
        end
      end
      DONE: begin
        state_nxt = LOAD;
      end
      default: begin
        state_nxt = LOAD;
        beat_nxt  = '0;
        t_nxt     = '0;
      end
    endcase
  end

  always_comb begin
    a_nxt = a_buf;
    b_nxt = b_buf;
    for (int k = 0; k < N; k++) begin
      if (accept && (beat == BW'(k))) begin
        for (int i = 0; i < N; i++) begin
          a_nxt[i][k] = in_a_col[i*DW +: DW];
          b_nxt[k][i] = in_b_row[i*DW +: DW];
        end
      end
    end
  end

  // Outputs are computed from the upcoming state and buffer contents so the first
  // stream cycle lines up with the final handshake, even when it uses that beat.
  always_comb begin
    left_nxt  = '0;
    up_nxt    = '0;
    valid_nxt = (state_nxt == STREAM);
    done_nxt  = (state_nxt == DONE);
    if (state_nxt == STREAM) begin
      for (int i = 0; i < N; i++) begin
        for (int k = 0; k < N; k++) begin
          if (t_nxt == TW'(i + k)) begin
            left_nxt[i*DW +: DW] = a_nxt[i][k];
            up_nxt[i*DW +: DW]   = b_nxt[k][i];
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_systolic_feeder.sv
// Directed bench for systolic_feeder with N=4, 8-bit lanes; A[i][k]=16i+k+1+aoff, B[k][j]=16k+j+0x81+boff.
module tb_systolic_feeder;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_a_col;
  logic [31:0] in_b_row;
  logic [31:0] out_left;
  logic [31:0] out_up;
  logic        out_valid;
  logic        busy;
  logic        done;

  int tests = 0;
  int fails = 0;

  systolic_feeder #(.data_width(8), .num_of_PE(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_a_col(in_a_col),
    .in_b_row(in_b_row),
    .out_left(out_left),
    .out_up(out_up),
    .out_valid(out_valid),
    .busy(busy),
    .done(done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] a, input logic [31:0] b);
    in_valid = v;
    in_a_col = a;
    in_b_row = b;
  endtask

  function automatic logic [31:0] a_col(input int k, input int aoff);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'(16 * i + k + 1 + aoff);
    return r;
  endfunction

  function automatic logic [31:0] b_row(input int k, input int boff);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[j*8 +: 8] = 8'(16 * k + j + 'h81 + boff);
    return r;
  endfunction

  function automatic logic [31:0] exp_left(input int t, input int aoff);
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < 4; i++)
      if (t - i >= 0 && t - i <= 3) r[i*8 +: 8] = 8'(16 * i + (t - i) + 1 + aoff);
    return r;
  endfunction

  function automatic logic [31:0] exp_up(input int t, input int boff);
    logic [31:0] r;
    r = '0;
    for (int j = 0; j < 4; j++)
      if (t - j >= 0 && t - j <= 3) r[j*8 +: 8] = 8'(16 * (t - j) + j + 'h81 + boff);
    return r;
  endfunction

  task automatic check_idle(input string tag);
    checkOutput({tag, "_ready"}, 32'(in_ready), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done"}, 32'(done), 32'd0);
    checkOutput({tag, "_left"}, out_left, 32'd0);
    checkOutput({tag, "_up"}, out_up, 32'd0);
  endtask

  task automatic check_cycle(input int t, input int aoff, input int boff);
    checkOutput($sformatf("t%0d_valid", t), 32'(out_valid), 32'd1);
    checkOutput($sformatf("t%0d_left", t), out_left, exp_left(t, aoff));
    checkOutput($sformatf("t%0d_up", t), out_up, exp_up(t, boff));
    checkOutput($sformatf("t%0d_ready", t), 32'(in_ready), 32'd0);
    checkOutput($sformatf("t%0d_busy", t), 32'(busy), 32'd1);
    checkOutput($sformatf("t%0d_done", t), 32'(done), 32'd0);
  endtask

  task automatic load_job(input int aoff, input int boff, input int first, input bit gap);
    for (int k = first; k < 4; k++) begin
      if (gap && k > first) begin
        repeat (3) begin
          @(negedge clk);
          checkOutput("gap_ready", 32'(in_ready), 32'd1);
          checkOutput("gap_valid", 32'(out_valid), 32'd0);
          applyStimulus(1'b0, $urandom(), $urandom());
        end
      end
      @(negedge clk);
      checkOutput($sformatf("load%0d_ready", k), 32'(in_ready), 32'd1);
      applyStimulus(1'b1, a_col(k, aoff), b_row(k, boff));
    end
  endtask

  task automatic stream_job(input int aoff, input int boff, input bit hold, input bit golden,
                            input int naoff, input int nboff);
    for (int t = 0; t < 10; t++) begin
      @(negedge clk);
      check_cycle(t, aoff, boff);
      if (golden) begin
        if (t == 0) begin
          checkOutput("gold_t0_left", out_left, 32'h0000_0001);
          checkOutput("gold_t0_up", out_up, 32'h0000_0081);
        end
        if (t == 1) begin
          checkOutput("gold_t1_left", out_left, 32'h0000_1102);
          checkOutput("gold_t1_up", out_up, 32'h0000_8291);
        end
        if (t == 6) begin
          checkOutput("gold_t6_left", out_left, 32'h3400_0000);
          checkOutput("gold_t6_up", out_up, 32'hB400_0000);
        end
        if (t >= 7) begin
          checkOutput("gold_flush_left", out_left, 32'h0);
          checkOutput("gold_flush_up", out_up, 32'h0);
        end
      end
      if (hold) applyStimulus(1'b1, $urandom(), $urandom());
      else applyStimulus(1'b0, 32'h0, 32'h0);
    end
    @(negedge clk);
    checkOutput("done_pulse", 32'(done), 32'd1);
    checkOutput("done_valid", 32'(out_valid), 32'd0);
    checkOutput("done_left", out_left, 32'd0);
    checkOutput("done_up", out_up, 32'd0);
    checkOutput("done_busy", 32'(busy), 32'd1);
    checkOutput("done_ready", 32'(in_ready), 32'd0);
    if (hold) applyStimulus(1'b1, a_col(0, naoff), b_row(0, nboff));
    @(negedge clk);
    check_idle("after_done");
  endtask

  initial begin
    applyStimulus(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    rst = 1'b1;

    $display("[TB] job 1: back-to-back beats");
    load_job(0, 0, 0, 1'b0);
    stream_job(0, 0, 1'b0, 1'b1, 0, 0);

    $display("[TB] job 2: beats separated by idle gaps");
    load_job(0, 0, 0, 1'b1);
    stream_job(0, 0, 1'b0, 1'b1, 0, 0);

    $display("[TB] job 3: in_valid held through stream and done");
    load_job('h40, 'h08, 0, 1'b0);
    stream_job('h40, 'h08, 1'b1, 1'b0, 'h20, 'h10);
    load_job('h20, 'h10, 1, 1'b0);
    stream_job('h20, 'h10, 1'b0, 1'b0, 0, 0);

    $display("[TB] reset during load");
    @(negedge clk);
    applyStimulus(1'b1, a_col(0, 'h11), b_row(0, 'h02));
    @(negedge clk);
    applyStimulus(1'b1, a_col(1, 'h11), b_row(1, 'h02));
    @(negedge clk);
    applyStimulus(1'b0, 32'h0, 32'h0);
    rst = 1'b0;
    #1;
    check_idle("rst_load");
    @(negedge clk);
    rst = 1'b1;
    load_job('h30, 'h04, 0, 1'b0);

    $display("[TB] reset mid-stream at t=4");
    for (int t = 0; t < 5; t++) begin
      @(negedge clk);
      check_cycle(t, 'h30, 'h04);
      applyStimulus(1'b0, 32'h0, 32'h0);
    end
    #1;
    rst = 1'b0;
    #1;
    check_idle("rst_stream");
    @(negedge clk);
    check_idle("rst_hold");
    rst = 1'b1;
    load_job('h10, 'h20, 0, 1'b0);
    stream_job('h10, 'h20, 1'b0, 1'b0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
